cpu5_memarb: RTL and testbench

- Arbiter sharing the single unified memory port between the instruction-fetch requester (pc/instr) and the data requester (dataaddr/writedata/readdata, LW/SW).
- Sits between the cpu5 core's fetch and load/store paths and the memory.
- One outstanding memory transaction at a time.
- Data has priority over fetch, with a bounded streak limit so fetch is never starved.

---
 rtl/cpu5_memarb_pkg.sv | 26 ++
 rtl/cpu5_memarb_pick.sv | 41 ++++
 rtl/cpu5_memarb.sv | 130 +++++++++++++
 tb/tb_cpu5_memarb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu5_memarb_pkg.sv
// Shared definitions for the cpu5 unified-memory arbiter: widths, state and owner encodings.
package cpu5_memarb_pkg;

   localparam int unsigned CPU5_XLEN            = 32;
   localparam int unsigned CPU5_MEMARB_ST_SIZE  = 2;
   localparam int unsigned CPU5_MEMARB_STREAK_W = 4;

   typedef enum logic [CPU5_MEMARB_ST_SIZE-1:0] {
      CPU5_MEMARB_IDLE = 2'd0,
      CPU5_MEMARB_REQ  = 2'd1,
      CPU5_MEMARB_WAIT = 2'd2
   } memarb_state_t;

   typedef enum logic {
      CPU5_MEMARB_OWN_IF = 1'b0,
      CPU5_MEMARB_OWN_D  = 1'b1
   } memarb_owner_t;

   function automatic logic [CPU5_MEMARB_STREAK_W-1:0] streak_inc_sat(
      input logic [CPU5_MEMARB_STREAK_W-1:0] cur,
      input logic [CPU5_MEMARB_STREAK_W-1:0] max_val
   );
      return (cur >= max_val) ? max_val : cur + 1'b1;
   endfunction

endpackage

// File: rtl/cpu5_memarb_pick.sv
// Grant decision for the memory arbiter: data first, but fetch is forced through
// after MAX_STREAK consecutive data grants taken while fetch was waiting.
module cpu5_memarb_pick
   import cpu5_memarb_pkg::*;
#(
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic arb,
   input  logic if_req_valid,
   input  logic d_req_valid,
   output logic grant_if,
   output logic grant_d
);

   localparam logic [CPU5_MEMARB_STREAK_W-1:0] MAX_S = CPU5_MEMARB_STREAK_W'(MAX_STREAK);

   logic [CPU5_MEMARB_STREAK_W-1:0] r_streak;
   logic                            w_at_max;

   always_comb begin
      w_at_max = (r_streak == MAX_S);
      grant_d  = arb & d_req_valid & ~(if_req_valid & w_at_max);
      grant_if = arb & if_req_valid & ~grant_d;
   end

   // Streak only moves on arbitration cycles; it holds while a transaction is in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_streak <= '0;
      end else if (arb) begin
         if (grant_if || !if_req_valid) begin
            r_streak <= '0;
         end else if (grant_d) begin
            r_streak <= streak_inc_sat(r_streak, MAX_S);
         end
      end
   end

endmodule

// File: rtl/cpu5_memarb.sv
// Arbiter sharing the single memory port between instruction fetch and load/store,
// one outstanding transaction at a time.
module cpu5_memarb
   import cpu5_memarb_pkg::*;
#(
   parameter int unsigned XLEN       = CPU5_XLEN,
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req_valid,
   input  logic [XLEN-1:0] if_req_addr,
   output logic            if_req_ready,
   output logic            if_rsp_valid,
   output logic [XLEN-1:0] if_rsp_data,
   input  logic            d_req_valid,
   input  logic            d_req_we,
   input  logic [XLEN-1:0] d_req_addr,
   input  logic [XLEN-1:0] d_req_wdata,
   output logic            d_req_ready,
   output logic            d_rsp_valid,
   output logic [XLEN-1:0] d_rsp_data,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            busy,
   output logic            err_unexp_rsp
);

   memarb_state_t r_state;
   memarb_state_t w_next_state;
   memarb_owner_t r_owner;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic            r_we;
   logic            r_mem_req_valid;
   logic            r_busy;
   logic            r_err;

   logic w_arb;
   logic w_grant_if;
   logic w_grant_d;
   logic w_latch;
   logic w_rsp_fire;

   // Arbitration is held off while reset is asserted so the ready pulses stay low too.
   assign w_arb = (r_state == CPU5_MEMARB_IDLE) && reset;

   cpu5_memarb_pick #(
      .MAX_STREAK (MAX_STREAK)
   ) u_pick (
      .clk          (clk),
      .reset        (reset),
      .arb          (w_arb),
      .if_req_valid (if_req_valid),
      .d_req_valid  (d_req_valid),
      .grant_if     (w_grant_if),
      .grant_d      (w_grant_d)
   );

   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      unique case (r_state)
         CPU5_MEMARB_IDLE: begin
            if (w_grant_if || w_grant_d) begin
               w_next_state = CPU5_MEMARB_REQ;
               w_latch      = 1'b1;
            end
         end
         CPU5_MEMARB_REQ: begin
            if (mem_req_ready) w_next_state = CPU5_MEMARB_WAIT;
         end
         CPU5_MEMARB_WAIT: begin
            if (mem_rsp_valid) w_next_state = CPU5_MEMARB_IDLE;
         end
         default: w_next_state = CPU5_MEMARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= CPU5_MEMARB_IDLE;
         r_mem_req_valid <= 1'b0;
         r_busy          <= 1'b0;
         r_err           <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_mem_req_valid <= (w_next_state == CPU5_MEMARB_REQ);
         r_busy          <= (w_next_state != CPU5_MEMARB_IDLE);
         r_err           <= mem_rsp_valid && (r_state != CPU5_MEMARB_WAIT);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner <= CPU5_MEMARB_OWN_IF;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else if (w_latch) begin
         r_owner <= w_grant_d ? CPU5_MEMARB_OWN_D : CPU5_MEMARB_OWN_IF;
         r_addr  <= w_grant_d ? d_req_addr : if_req_addr;
         r_we    <= w_grant_d & d_req_we;
         r_wdata <= w_grant_d ? d_req_wdata : '0;
      end
   end

   always_comb begin
      w_rsp_fire   = (r_state == CPU5_MEMARB_WAIT) && mem_rsp_valid;
      if_rsp_valid = w_rsp_fire && (r_owner == CPU5_MEMARB_OWN_IF);
      d_rsp_valid  = w_rsp_fire && (r_owner == CPU5_MEMARB_OWN_D);
      if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
      d_rsp_data   = d_rsp_valid ? mem_rdata : '0;
   end

   assign if_req_ready  = w_grant_if;
   assign d_req_ready   = w_grant_d;
   assign mem_req_valid = r_mem_req_valid;
   assign mem_addr      = r_addr;
   assign mem_we        = r_we;
   assign mem_wdata     = r_wdata;
   assign busy          = r_busy;
   assign err_unexp_rsp = r_err;

endmodule

// File: tb/tb_cpu5_memarb.sv
// Randomized bench for cpu5_memarb with a transaction-level reference model of the arbiter.
module tb_cpu5_memarb;

   localparam int XLEN = 32;
   localparam int MAXS = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            if_req_valid;
   logic [XLEN-1:0] if_req_addr;
   logic            if_req_ready;
   logic            if_rsp_valid;
   logic [XLEN-1:0] if_rsp_data;
   logic            d_req_valid;
   logic            d_req_we;
   logic [XLEN-1:0] d_req_addr;
   logic [XLEN-1:0] d_req_wdata;
   logic            d_req_ready;
   logic            d_rsp_valid;
   logic [XLEN-1:0] d_rsp_data;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_addr;
   logic            mem_we;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rdata;
   logic            busy;
   logic            err_unexp_rsp;

   always #5 clk = ~clk;

   cpu5_memarb #(
      .XLEN       (XLEN),
      .MAX_STREAK (MAXS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .if_req_valid  (if_req_valid),
      .if_req_addr   (if_req_addr),
      .if_req_ready  (if_req_ready),
      .if_rsp_valid  (if_rsp_valid),
      .if_rsp_data   (if_rsp_data),
      .d_req_valid   (d_req_valid),
      .d_req_we      (d_req_we),
      .d_req_addr    (d_req_addr),
      .d_req_wdata   (d_req_wdata),
      .d_req_ready   (d_req_ready),
      .d_rsp_valid   (d_rsp_valid),
      .d_rsp_data    (d_rsp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wdata     (mem_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rdata     (mem_rdata),
      .busy          (busy),
      .err_unexp_rsp (err_unexp_rsp)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: one pending transaction, split into "address phase" and "data phase".
   bit              m_busy;
   bit              m_sent;
   bit              m_own_d;
   bit              m_we;
   bit              m_err_q;
   bit              last_gi;
   bit              last_gd;
   logic [XLEN-1:0] m_addr;
   logic [XLEN-1:0] m_wdata;
   int              m_streak;
   int              cyc = 0;
   bit              dut_order[$];
   int              d_acc_cyc[$];

   task automatic model_reset();
      m_busy = 0; m_sent = 0; m_own_d = 0; m_we = 0; m_err_q = 0;
      last_gi = 0; last_gd = 0; m_addr = '0; m_wdata = '0; m_streak = 0;
   endtask

   task automatic idle_inputs();
      if_req_valid = 0; if_req_addr = '0;
      d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
   endtask

   // Called at posedge+1 with inputs already applied; checks at negedge, then advances the model.
   task automatic step();
      bit gi, gd, rsp;
      gi = 0; gd = 0;
      if (!m_busy) begin
         gd = d_req_valid && !(if_req_valid && m_streak == MAXS);
         gi = if_req_valid && !gd;
      end
      rsp = m_busy && m_sent && mem_rsp_valid;
      @(negedge clk);
      check_eq("if_req_ready", 32'(if_req_ready), 32'(gi));
      check_eq("d_req_ready", 32'(d_req_ready), 32'(gd));
      check_eq("mem_req_valid", 32'(mem_req_valid), 32'(m_busy && !m_sent));
      if (m_busy && !m_sent) begin
         check_eq("mem_addr", mem_addr, m_addr);
         check_eq("mem_we", 32'(mem_we), 32'(m_we));
         check_eq("mem_wdata", mem_wdata, m_wdata);
      end
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("if_rsp_valid", 32'(if_rsp_valid), 32'(rsp && !m_own_d));
      check_eq("d_rsp_valid", 32'(d_rsp_valid), 32'(rsp && m_own_d));
      if (rsp && !m_own_d) check_eq("if_rsp_data", if_rsp_data, mem_rdata);
      if (rsp && m_own_d && !m_we) check_eq("d_rsp_data", d_rsp_data, mem_rdata);
      check_eq("err_unexp_rsp", 32'(err_unexp_rsp), 32'(m_err_q));
      if (if_req_ready) dut_order.push_back(1'b0);
      if (d_req_ready) begin
         dut_order.push_back(1'b1);
         d_acc_cyc.push_back(cyc);
      end

      m_err_q = mem_rsp_valid && !(m_busy && m_sent);
      if (!m_busy) begin
         if (gi || gd) begin
            m_busy = 1; m_sent = 0; m_own_d = gd;
            m_addr  = gd ? d_req_addr : if_req_addr;
            m_we    = gd && d_req_we;
            m_wdata = gd ? d_req_wdata : '0;
         end
         if (gi || !if_req_valid) m_streak = 0;
         else if (gd) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
      end else if (!m_sent) begin
         if (mem_req_ready) m_sent = 1;
      end else if (mem_rsp_valid) begin
         m_busy = 0;
      end
      last_gi = gi;
      last_gd = gd;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // mode 0: random requesters (with occasional withdrawal); mode 1: both always requesting.
   task automatic drive_reqs(input int mode);
      if (if_req_valid && !last_gi) begin
         if (mode == 0 && $urandom_range(0, 15) == 0) if_req_valid = 1'b0;
      end else begin
         if_req_valid = (mode == 1) || ($urandom_range(0, 2) == 0);
         if_req_addr  = $urandom & ~32'h3;
      end
      if (d_req_valid && !last_gd) begin
         if (mode == 0 && $urandom_range(0, 15) == 0) d_req_valid = 1'b0;
      end else begin
         d_req_valid = (mode == 1) || ($urandom_range(0, 1) == 0);
         d_req_we    = ($urandom_range(0, 1) == 1);
         d_req_addr  = $urandom & ~32'h3;
         d_req_wdata = $urandom;
      end
   endtask

   // mode 0: random stalls and stray responses; mode 1: zero-wait memory.
   task automatic drive_mem(input int mode);
      mem_rdata = $urandom;
      if (mode == 1) begin
         mem_req_ready = 1'b1;
         mem_rsp_valid = m_busy && m_sent;
      end else begin
         mem_req_ready = ($urandom_range(0, 2) != 0);
         mem_rsp_valid = (m_busy && m_sent) ? ($urandom_range(0, 1) == 1)
                                            : ($urandom_range(0, 24) == 0);
      end
   endtask

   task automatic drain();
      if_req_valid = 0;
      d_req_valid  = 0;
      repeat (6) begin
         drive_mem(1);
         step();
      end
      idle_inputs();
      step();
   endtask

   initial begin
      bit exp_ord [10];
      logic [XLEN-1:0] got;
      int n;

      reset = 1'b1;
      idle_inputs();
      model_reset();
      #1 reset = 1'b0;
      #1;
      check_eq("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_mem_addr", mem_addr, '0);
      check_eq("rst_err", 32'(err_unexp_rsp), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      step();

      // single fetch
      if_req_valid = 1; if_req_addr = 32'h100; mem_req_ready = 1;
      step();
      if_req_valid = 0;
      step();
      mem_rsp_valid = 1; mem_rdata = 32'h00A0_0093;
      step();
      mem_rsp_valid = 0;
      step();

      // store held through three stalled cycles; payload change after accept
      d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h2000; d_req_wdata = 32'hDEAD_BEEF;
      mem_req_ready = 0;
      step();
      d_req_valid = 0; d_req_wdata = 32'h0; d_req_addr = 32'h0;
      repeat (3) step();
      mem_req_ready = 1;
      step();
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h5555_AAAA;
      step();
      mem_rsp_valid = 0;
      step();

      // stray response while idle
      mem_rsp_valid = 1;
      step();
      mem_rsp_valid = 0;
      step();
      step();

      // reset while waiting for a response
      d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h40; mem_req_ready = 1;
      step();
      d_req_valid = 0;
      step();
      mem_req_ready = 0;
      #2 reset = 1'b0;
      #1;
      check_eq("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_mem_we", 32'(mem_we), 32'd0);
      check_eq("midrst_mem_addr", mem_addr, '0);
      check_eq("midrst_rsp", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);
      check_eq("midrst_ready", 32'({if_req_ready, d_req_ready}), 32'd0);
      model_reset();
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
      step();
      mem_rsp_valid = 0;
      step();
      step();

      // contention: both requesters always valid
      idle_inputs();
      step();
      dut_order.delete();
      repeat (40) begin
         drive_reqs(1);
         drive_mem(1);
         step();
      end
      exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 10; i++) begin
         got = (i < dut_order.size()) ? 32'(dut_order[i]) : 32'hFFFF_FFFF;
         check_eq("grant_order", got, 32'(exp_ord[i]));
      end
      drain();

      // back-to-back loads with zero-wait memory
      d_acc_cyc.delete();
      d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h10; d_req_wdata = '0;
      n = 0;
      for (int k = 0; k < 12; k++) begin
         drive_mem(1);
         step();
         if (last_gd) begin
            n++;
            if (n == 1) d_req_addr = 32'h14;
            else d_req_valid = 0;
         end
      end
      check_eq("b2b_count", 32'(d_acc_cyc.size()), 32'd2);
      got = (d_acc_cyc.size() >= 2) ? 32'(d_acc_cyc[1] - d_acc_cyc[0]) : 32'hFFFF_FFFF;
      check_eq("b2b_spacing", got, 32'd3);
      drain();

      // randomized traffic
      repeat (3000) begin
         drive_reqs(0);
         drive_mem(0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
